idct_pixel_sink: RTL and testbench
==================================

# idct_pixel_sink

Pixel-side endpoint of the DCT→IDCT chain. It captures 64-sample IDCT output bursts (`done` + `dout`), extracts and optionally saturates the 8-bit pixel field, and buffers complete blocks in a two-bank ping-pong memory. It then re-emits the pixels as a ready/valid byte stream with block framing. This replaces the simulation-only file dump with synthesizable logic, so reconstructed images can leave the chip at the downstream consumer's rate.

## Interface
- `BitWidth`, 31 — MSB index of `dout` (bus is `BitWidth+1` bits).
- `PixLsb`, 17 — LSB of the 8-bit pixel field; pixel = `dout[PixLsb+7:PixLsb]`.
- `clk` input 1 — single clock, rising edge.
- `reset` input 1 — synchronous, active-high.
- `done` input 1 — IDCT output-valid burst flag; one sample per cycle while high.
- `dout` input `BitWidth+1` — IDCT output word, two's complement.
- `pix_ready` input 1 — downstream accepts `pix_data` when high with `pix_valid`.
- `pix_valid` output 1 — `pix_data` is valid.
- `pix_data` output 8 — reconstructed pixel.
- `pix_last` output 1 — marks pixel 63 of a block (qualified by `pix_valid`).
- `blk_count` output 16 — number of blocks fully drained; wraps at 65535→0.
- `ovf` output 1 — sticky: a burst was dropped because both banks were full.
- `short_blk` output 1 — sticky: `done` fell before 64 samples.

## Operation
- Reset: all outputs 0. Both banks are marked empty and both bank pointers are set to bank 0. Write FSM is `W_IDLE`; read FSM is `R_IDLE`.
- Write FSM:
  - `W_IDLE`:
    - `done`=1 and the write bank is empty → capture sample 0 and go to `W_FILL`.
    - `done`=1 and the write bank is full → go to `W_DROP` and set `ovf`.
  - `W_FILL`: capture one sample per cycle while `done`=1. The sample index runs 0..63.
    - On capturing sample 63: mark the bank full, toggle the write pointer, go to `W_WAIT`.
    - `done`=0 before 63 → discard the partial bank (it stays empty), set `short_blk`, return to `W_IDLE`.
  - `W_WAIT` / `W_DROP`: ignore samples until `done`=0, then go to `W_IDLE`.
  - Samples beyond the 64th in one burst are ignored. A new block always requires `done` to go low and then high again.
- Read FSM:
  - `R_IDLE`: when the read bank is full → go to `R_DRAIN`.
  - `R_DRAIN`: present pixels 0..63 in order; a pixel advances on `pix_valid & pix_ready`.
    - `pix_last`=1 on pixel 63.
    - Acceptance of pixel 63 marks the bank empty, toggles the read pointer, and increments `blk_count`.
    - If the other bank is full, draining continues with no bubble; otherwise go to `R_IDLE`.
- Blocks are emitted strictly in capture order. A dropped burst leaves no trace except `ovf`.
- While `pix_valid`=1 and `pix_ready`=0, `pix_data` and `pix_last` are held stable.
- Same-cycle bank commit (write side) and bank release (read side) both take effect.
- Pixel extraction: `v = dout >>> PixLsb` (arithmetic shift). See Configuration.
- `ovf` and `short_blk` clear only on `reset`.

## Timing
- Capture: a sample is written on the rising edge where `done`=1 (same-edge sampling, no input register).
- Latency: when the read side is idle, `pix_valid` rises at the 2nd rising edge after the edge that captures sample 63.
- Throughput: 1 pixel/cycle with `pix_ready` held high. A block drains in exactly 64 cycles. Back-to-back full banks drain in 128 consecutive valid cycles.
- A bank becomes writable on the edge after its pixel 63 is accepted, so a burst starting that next cycle is captured.
- Synchronous `reset` asserted mid-burst or mid-drain:
  - takes effect at that edge;
  - in-flight data is lost;
  - `pix_valid` is 0 from the following cycle until a new block completes.
- Bank memory is one write port and one registered read port per bank. Memory contents are not reset.

## Configuration
- `IDCT_PIX_SAT_EN` defined:
  - `v` < 0 → `pix_data` = 0.
  - `v` > 255 → `pix_data` = 255.
  - Otherwise `pix_data` = `v[7:0]`.
- Undefined: `pix_data` = `dout[PixLsb+7:PixLsb]` raw (wrap-around), bit-exact with the existing `idctdata.txt` dump format.

## Test plan
- Single block: `done` high 64 cycles, `dout` = i<<17 (i = 0..63), `pix_ready`=1 → `pix_data` 0..63 beginning 2 edges after the last sample. `pix_last` is set on value 63; `blk_count`=1.
- Saturation: with `IDCT_PIX_SAT_EN`, samples `dout` = −5<<17, 300<<17, 128<<17 → 0, 255, 128. Without the macro → 251, 44, 128.
- Backpressure and overflow: `pix_ready`=0 and three 64-sample bursts → the first two bursts are stored, the third is dropped, and `ovf`=1. Then raise `pix_ready` → 128 pixels in order with no bubble; `blk_count`=2.
- Short burst: `done` high 40 cycles, then a full 64-cycle burst → `short_blk`=1 and only the 64-sample block is emitted.
- Long burst: `done` high 80 cycles → exactly 64 pixels are emitted (samples 64..79 ignored).
- Reset mid-drain: assert `reset` after 10 pixels are accepted → all outputs 0 the next cycle, then a fresh block is emitted correctly.

Source files
------------

// File: rtl/idct_pixel_sink.sv
// idct_pixel_sink: captures 64-sample IDCT output bursts into a two-bank
// ping-pong buffer and replays each complete block as a ready/valid byte
// stream. pix_last marks the final pixel of each block.
// Optional feature macro: IDCT_PIX_SAT_EN. When it is defined, each pixel is
// saturated to 0..255. When it is undefined, the raw 8-bit field is passed
// through unchanged.
`timescale 1ns/1ps

module idct_pixel_sink #(
    parameter int BitWidth = 31,
    parameter int PixLsb   = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              done,
    input  logic [BitWidth:0] dout,
    input  logic              pix_ready,
    output logic              pix_valid,
    output logic [7:0]        pix_data,
    output logic              pix_last,
    output logic [15:0]       blk_count,
    output logic              ovf,
    output logic              short_blk
);

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_WAIT, W_DROP} w_state_t;
    typedef enum logic {R_IDLE, R_DRAIN} r_state_t;

    w_state_t    w_state_reg;
    logic        wr_bank_reg;
    logic [5:0]  wr_idx_reg;
    logic [1:0]  bank_full_reg;

    r_state_t    r_state_reg;
    logic        rd_bank_reg;
    logic [5:0]  rd_idx_reg;
    logic        sel_reg;
    logic        pix_valid_reg;
    logic        pix_last_reg;
    logic [15:0] blk_count_reg;
    logic        ovf_reg;
    logic        short_blk_reg;

    logic [7:0]  pix_in;
    logic        cap;
    logic        commit;
    logic [5:0]  wr_addr;
    logic        advance;
    logic        blk_release;
    logic        chain_next;
    logic        pix_load;
    logic        load_bank;
    logic [5:0]  load_addr;
    logic [1:0]  bank_set;
    logic [1:0]  bank_clr;
    logic [15:0] bank_q;
    logic        dout_unused;

    // Only the pixel field (or the arithmetically shifted word) is used.
    assign dout_unused = ^dout;

`ifdef IDCT_PIX_SAT_EN
    logic signed [BitWidth:0] shifted;
    assign shifted = $signed(dout) >>> PixLsb;

    // Clamp the shifted value into the 0..255 pixel range.
    always_comb begin
        pix_in = shifted[7:0];
        if (shifted[BitWidth]) begin
            pix_in = 8'd0;
        end else if (|shifted[BitWidth-1:8]) begin
            pix_in = 8'hFF;
        end
    end
`else
    assign pix_in = dout[PixLsb+7 -: 8];
`endif

    // Capture decision and write address for the current sample.
    always_comb begin
        cap     = 1'b0;
        commit  = 1'b0;
        wr_addr = wr_idx_reg;
        case (w_state_reg)
            W_IDLE: begin
                cap     = done && !bank_full_reg[wr_bank_reg];
                wr_addr = 6'd0;
            end
            W_FILL: begin
                cap    = done;
                commit = done && (wr_idx_reg == 6'd63);
            end
            W_WAIT, W_DROP: begin
                cap = 1'b0;
            end
        endcase
    end

    // The output slot moves when it is empty or its pixel is being taken.
    // Taking pixel 63 releases the bank. If the other bank is already full,
    // its pixel 0 is loaded in the same cycle so there is no gap between blocks.
    assign advance     = (r_state_reg == R_DRAIN) && (!pix_valid_reg || pix_ready);
    assign blk_release = advance && pix_valid_reg && pix_last_reg;
    assign chain_next  = blk_release && bank_full_reg[~rd_bank_reg];
    assign pix_load    = advance && (!blk_release || chain_next);
    assign load_bank   = blk_release ? ~rd_bank_reg : rd_bank_reg;
    assign load_addr   = blk_release ? 6'd0 : rd_idx_reg;

    assign bank_set = {commit && wr_bank_reg, commit && !wr_bank_reg};
    assign bank_clr = {blk_release && rd_bank_reg, blk_release && !rd_bank_reg};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic [7:0] mem [64];
            logic [7:0] q_reg;
            logic       we;
            logic       re;

            assign we = cap && (wr_bank_reg == 1'(gi));
            assign re = pix_load && (load_bank == 1'(gi));

            // Single write port and registered read port for this bank.
            always_ff @(posedge clk) begin
                if (we) begin
                    mem[wr_addr] <= pix_in;
                end
                if (re) begin
                    q_reg <= mem[load_addr];
                end
            end

            assign bank_q[gi*8 +: 8] = q_reg;
        end
    endgenerate

    // Write FSM: fill the write bank from one burst. A short burst is
    // discarded, and a burst that finds its bank still full is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_state_reg   <= W_IDLE;
            wr_bank_reg   <= 1'b0;
            wr_idx_reg    <= 6'd0;
            ovf_reg       <= 1'b0;
            short_blk_reg <= 1'b0;
        end else begin
            case (w_state_reg)
                W_IDLE: begin
                    if (done) begin
                        if (!bank_full_reg[wr_bank_reg]) begin
                            wr_idx_reg  <= 6'd1;
                            w_state_reg <= W_FILL;
                        end else begin
                            ovf_reg     <= 1'b1;
                            w_state_reg <= W_DROP;
                        end
                    end
                end
                W_FILL: begin
                    if (done) begin
                        if (wr_idx_reg == 6'd63) begin
                            wr_bank_reg <= ~wr_bank_reg;
                            wr_idx_reg  <= 6'd0;
                            w_state_reg <= W_WAIT;
                        end else begin
                            wr_idx_reg <= wr_idx_reg + 6'd1;
                        end
                    end else begin
                        short_blk_reg <= 1'b1;
                        wr_idx_reg    <= 6'd0;
                        w_state_reg   <= W_IDLE;
                    end
                end
                W_WAIT, W_DROP: begin
                    if (!done) begin
                        w_state_reg <= W_IDLE;
                    end
                end
            endcase
        end
    end

    // Bank occupancy: the write side sets a bank full and the read side
    // clears one. Both can happen in the same cycle, always on different banks.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_full_reg <= 2'b00;
        end else begin
            bank_full_reg <= (bank_full_reg | bank_set) & ~bank_clr;
        end
    end

    // Read FSM: drain full banks in capture order through the output slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_reg   <= R_IDLE;
            rd_bank_reg   <= 1'b0;
            rd_idx_reg    <= 6'd0;
            sel_reg       <= 1'b0;
            pix_valid_reg <= 1'b0;
            pix_last_reg  <= 1'b0;
            blk_count_reg <= 16'd0;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    if (bank_full_reg[rd_bank_reg]) begin
                        rd_idx_reg  <= 6'd0;
                        r_state_reg <= R_DRAIN;
                    end
                end
                R_DRAIN: begin
                    if (blk_release) begin
                        rd_bank_reg   <= ~rd_bank_reg;
                        blk_count_reg <= blk_count_reg + 16'd1;
                        pix_last_reg  <= 1'b0;
                        if (chain_next) begin
                            pix_valid_reg <= 1'b1;
                            sel_reg       <= ~rd_bank_reg;
                            rd_idx_reg    <= 6'd1;
                        end else begin
                            pix_valid_reg <= 1'b0;
                            r_state_reg   <= R_IDLE;
                        end
                    end else if (pix_load) begin
                        pix_valid_reg <= 1'b1;
                        pix_last_reg  <= (rd_idx_reg == 6'd63);
                        sel_reg       <= rd_bank_reg;
                        rd_idx_reg    <= rd_idx_reg + 6'd1;
                    end
                end
            endcase
        end
    end

    assign pix_valid = pix_valid_reg;
    assign pix_last  = pix_last_reg;
    assign pix_data  = pix_valid_reg ? (sel_reg ? bank_q[15:8] : bank_q[7:0]) : 8'd0;
    assign blk_count = blk_count_reg;
    assign ovf       = ovf_reg;
    assign short_blk = short_blk_reg;

endmodule

// File: tb/tb_idct_pixel_sink.sv
// Scoreboard bench for idct_pixel_sink. Expected pixels are queued as bursts
// are driven and popped when pixels are accepted downstream.
// It also covers the IDCT_PIX_SAT_EN build when that macro is defined.
`timescale 1ns/1ps

module tb_idct_pixel_sink;

    logic        clk = 1'b0;
    logic        reset;
    logic        done;
    logic [31:0] dout;
    logic        pix_ready;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        pix_last;
    logic [15:0] blk_count;
    logic        ovf;
    logic        short_blk;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t sb_q[$];
    int   checks_cnt = 0;
    int   err_cnt    = 0;
    int   acc_cnt    = 0;
    int   exp_blk    = 0;
    int   burst_vals [80];

    idct_pixel_sink #(.BitWidth(31), .PixLsb(17)) dut (
        .clk       (clk),
        .reset     (reset),
        .done      (done),
        .dout      (dout),
        .pix_ready (pix_ready),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_last  (pix_last),
        .blk_count (blk_count),
        .ovf       (ovf),
        .short_blk (short_blk)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_pix(input int v);
`ifdef IDCT_PIX_SAT_EN
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return 8'(v);
`else
        return 8'(v & 255);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive n samples from burst_vals. If keep is set, queue the first 64.
    task automatic send_burst(input int n, input bit keep);
        for (int i = 0; i < n; i++) begin
            done = 1'b1;
            dout = 32'(burst_vals[i]) << 17;
            if (keep && i < 64) begin
                sb_q.push_back('{data: exp_pix(burst_vals[i]), last: (i == 63)});
            end
            tick();
        end
        done = 1'b0;
        dout = 32'd0;
        if (keep) exp_blk++;
        $display("burst len=%0d kept=%0d queued=%0d", n, keep, sb_q.size());
    endtask

    task automatic fill_random();
        for (int i = 0; i < 80; i++) begin
            burst_vals[i] = int'($urandom_range(0, 600)) - 200;
        end
    endtask

    task automatic wait_drain(input int budget);
        for (int c = 0; c < budget; c++) begin
            if (sb_q.size() == 0 && !pix_valid) break;
            tick();
        end
        check_eq("drain_queue", 32'(sb_q.size()), 32'd0);
        for (int c = 0; c < 6; c++) tick();
        check_eq("blk_count", 32'(blk_count), 32'(exp_blk));
    endtask

    // Pop and compare every pixel that is accepted downstream.
    always @(negedge clk) begin
        if (!reset && pix_valid && pix_ready) begin
            exp_t e;
            acc_cnt++;
            if (sb_q.size() == 0) begin
                check_eq("sb_empty", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check_eq("pix_data", 32'(pix_data), 32'(e.data));
                check_eq("pix_last", 32'(pix_last), 32'(e.last));
                if (e.last) $display("block drained data_last=%0d", pix_data);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcnt;
        reset     = 1'b1;
        done      = 1'b0;
        dout      = 32'd0;
        pix_ready = 1'b0;
        tick(); tick(); tick();
        check_eq("rst_valid", 32'(pix_valid), 32'd0);
        check_eq("rst_data", 32'(pix_data), 32'd0);
        check_eq("rst_last", 32'(pix_last), 32'd0);
        check_eq("rst_blk", 32'(blk_count), 32'd0);
        check_eq("rst_ovf", 32'(ovf), 32'd0);
        check_eq("rst_short", 32'(short_blk), 32'd0);
        reset = 1'b0;
        tick();

        // Single block with a ramp, checking the two-edge latency.
        pix_ready = 1'b1;
        for (int i = 0; i < 80; i++) burst_vals[i] = i;
        send_burst(64, 1'b1);
        check_eq("lat_e0", 32'(pix_valid), 32'd0);
        tick();
        check_eq("lat_e1", 32'(pix_valid), 32'd0);
        tick();
        check_eq("lat_e2", 32'(pix_valid), 32'd1);
        wait_drain(200);

        // Saturation and wrap corner values.
        fill_random();
        burst_vals[0] = -5;
        burst_vals[1] = 300;
        burst_vals[2] = 128;
        send_burst(64, 1'b1);
        wait_drain(200);

        // Backpressure with overflow: two bursts are stored and the third is dropped.
        pix_ready = 1'b0;
        fill_random();
        send_burst(64, 1'b1);
        tick();
        fill_random();
        send_burst(64, 1'b1);
        tick();
        fill_random();
        send_burst(64, 1'b0);
        tick(); tick(); tick();
        check_eq("ovf", 32'(ovf), 32'd1);
        check_eq("hold_valid", 32'(pix_valid), 32'd1);
        check_eq("hold_data0", 32'(pix_data), 32'(sb_q[0].data));
        for (int c = 0; c < 5; c++) tick();
        check_eq("hold_data1", 32'(pix_data), 32'(sb_q[0].data));
        check_eq("hold_last", 32'(pix_last), 32'd0);
        pix_ready = 1'b1;
        vcnt = 0;
        for (int c = 0; c < 128; c++) begin
            if (pix_valid) vcnt++;
            tick();
        end
        check_eq("no_bubble", 32'(vcnt), 32'd128);
        check_eq("idle_after", 32'(pix_valid), 32'd0);
        wait_drain(50);

        // Short burst followed by a full burst.
        fill_random();
        send_burst(40, 1'b0);
        tick();
        fill_random();
        send_burst(64, 1'b1);
        check_eq("short_blk", 32'(short_blk), 32'd1);
        wait_drain(200);

        // Long burst: only the first 64 samples are kept.
        fill_random();
        send_burst(80, 1'b1);
        wait_drain(200);

        // Reset after 10 pixels of a drain.
        fill_random();
        vcnt = acc_cnt + 10;
        send_burst(64, 1'b1);
        for (int c = 0; c < 100; c++) begin
            if (acc_cnt >= vcnt) break;
            tick();
        end
        check_eq("acc10", 32'(acc_cnt), 32'(vcnt));
        reset     = 1'b1;
        pix_ready = 1'b0;
        tick();
        check_eq("mid_valid", 32'(pix_valid), 32'd0);
        check_eq("mid_data", 32'(pix_data), 32'd0);
        check_eq("mid_last", 32'(pix_last), 32'd0);
        check_eq("mid_blk", 32'(blk_count), 32'd0);
        check_eq("mid_ovf", 32'(ovf), 32'd0);
        check_eq("mid_short", 32'(short_blk), 32'd0);
        sb_q.delete();
        exp_blk = 0;
        reset = 1'b0;
        tick();
        check_eq("post_rst_valid", 32'(pix_valid), 32'd0);
        pix_ready = 1'b1;
        fill_random();
        send_burst(64, 1'b1);
        wait_drain(200);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, err_cnt);
        $finish;
    end

endmodule
